// File: rtl/align_lane_scheduler.sv
// rtl/align_lane_scheduler.sv - Group scheduler: word load, lane sel window, settle and lock-step drain
module align_lane_scheduler #(
   parameter int N_LANES       = 4,
   parameter int W             = 32,
   parameter int SEL_CYCLES    = 7,
   parameter int SETTLE_CYCLES = 3,
   parameter int STALL_MAX     = 15
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic                 in_last,
   output logic [N_LANES-1:0]   lane_sel,
   output logic [N_LANES*W-1:0] lane_data,
   input  logic [N_LANES-1:0]   lane_full,
   input  logic [N_LANES-1:0]   lane_empty,
   output logic                 global_re,
   output logic                 out_valid,
   output logic                 group_done,
   output logic                 err_overflow,
   output logic                 err_timeout
);

   localparam int WCW    = $clog2(N_LANES + 1);
   localparam int PH_MAX = (SEL_CYCLES > SETTLE_CYCLES) ? SEL_CYCLES : SETTLE_CYCLES;
   localparam int PCW    = $clog2(PH_MAX + 1);
   localparam int SCW    = $clog2(STALL_MAX + 1);

   localparam logic [WCW-1:0] WC_LAST     = WCW'(N_LANES - 1);
   localparam logic [PCW-1:0] PH_SEL_LAST = PCW'(SEL_CYCLES - 1);
   localparam logic [PCW-1:0] PH_SET_LAST = PCW'(SETTLE_CYCLES - 1);
   localparam logic [SCW-1:0] ST_LAST     = SCW'(STALL_MAX - 1);

   typedef enum logic [1:0] {S_LOAD, S_ARM, S_SETTLE, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [WCW-1:0]         wcnt_q, wcnt_d;
   logic                   locked_q, locked_d;
   logic [N_LANES*W-1:0]   data_q, data_d;
   logic [PCW-1:0]         phase_q, phase_d;
   logic [SCW-1:0]         stall_q, stall_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   tmo_q, tmo_d;
   logic                   re;

   // Next-state logic: load words, run the sel window, settle, then drain with stall watchdog
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      locked_d = locked_q;
      data_d   = data_q;
      phase_d  = phase_q;
      stall_d  = stall_q;
      ovf_d    = ovf_q;
      tmo_d    = tmo_q;
      done_d   = 1'b0;
      re       = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            if (in_valid && in_ready_q) begin
               for (int i = 0; i < N_LANES; i++) begin
                  if (int'(wcnt_q) == i) data_d[i*W +: W] = in_data;
               end
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_q == WC_LAST || in_last) locked_d = 1'b1;
            end
            // The lock takes effect one cycle before ARM so lanes are always checked empty first
            if (locked_q && (&lane_empty)) begin
               state_d = S_ARM;
               phase_d = '0;
            end
         end
         S_ARM: begin
            if (|lane_full) ovf_d = 1'b1;
            if (phase_q == PH_SEL_LAST) begin
               state_d = S_SETTLE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (phase_q == PH_SET_LAST) begin
               state_d = S_DRAIN;
               phase_d = '0;
               stall_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (&(~lane_empty)) begin
               re      = 1'b1;
               stall_d = '0;
               if (phase_q == PH_SEL_LAST) begin
                  done_d  = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end else if (stall_q == ST_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_LOAD;
            end else begin
               stall_d = stall_q + 1'b1;
            end
            // Leaving DRAIN (normal or abort) releases the group for the next load
            if (state_d == S_LOAD) begin
               wcnt_d   = '0;
               locked_d = 1'b0;
               data_d   = '0;
               phase_d  = '0;
               stall_d  = '0;
            end
         end
         default: state_d = S_LOAD;
      endcase
      in_ready_d = (state_d == S_LOAD) && !locked_d;
   end

   // State and datapath registers; out_valid mirrors the one-cycle FIFO read latency
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_LOAD;
         wcnt_q      <= '0;
         locked_q    <= 1'b0;
         data_q      <= '0;
         phase_q     <= '0;
         stall_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         locked_q    <= locked_d;
         data_q      <= data_d;
         phase_q     <= phase_d;
         stall_q     <= stall_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= re;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         tmo_q       <= tmo_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign lane_sel     = {N_LANES{state_q == S_ARM}};
   assign lane_data    = data_q;
   assign global_re    = re;
   assign out_valid    = out_valid_q;
   assign group_done   = done_q;
   assign err_overflow = ovf_q;
   assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_align_lane_scheduler.sv
// tb/tb_align_lane_scheduler.sv - Self-checking bench for align_lane_scheduler
module tb_align_lane_scheduler;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_last = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic           in_ready;
   logic [N-1:0]   lane_sel;
   logic [N*W-1:0] lane_data;
   logic [N-1:0]   lane_full = '0;
   logic [N-1:0]   lane_empty;
   logic           global_re, out_valid, group_done, err_overflow, err_timeout;

   logic [N-1:0]   force_e = '0;
   logic [N-1:0]   force_ne = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           n;
      logic [127:0] words;
      logic         last;
      logic [127:0] exp_data;
      int           exp_lat;
   } vec_t;
   vec_t vecs[5];

   logic [127:0] exp_q[$];

   int cyc = 0;
   int n_sel = 0, n_re = 0, n_ov = 0, n_done = 0;
   int last_sel_cyc = 0, sel_rise_cyc = 0, first_re_cyc = 0, last_re_cyc = 0;
   int done_cyc = 0, tmo_cyc = 0, grp_acc = 0;
   bit re_pending = 0, prev_re = 0, prev_sel = 0, prev_tmo = 0;
   int b_sel, b_re, b_ov, b_done;

   align_lane_scheduler dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .lane_sel     (lane_sel),
      .lane_data    (lane_data),
      .lane_full    (lane_full),
      .lane_empty   (lane_empty),
      .global_re    (global_re),
      .out_valid    (out_valid),
      .group_done   (group_done),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   // Lane FIFO occupancy model: writes land two cycles after sel, reads follow global_re
   int   occ;
   logic sel_p1, sel_p2;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         occ    <= 0;
         sel_p1 <= 1'b0;
         sel_p2 <= 1'b0;
      end else begin
         sel_p1 <= lane_sel[0];
         sel_p2 <= sel_p1;
         occ    <= occ + int'(sel_p2) - int'(global_re);
      end
   end
   assign lane_empty = (((occ == 0) ? 4'hF : 4'h0) & ~force_ne) | force_e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: event counters, out_valid lag, scoreboard pop at ARM entry
   always @(negedge clk) begin
      cyc++;
      if (!resetn) begin
         prev_re  = 1'b0;
         prev_sel = 1'b0;
         prev_tmo = 1'b0;
      end else begin
         chk("out_valid_lag", 128'(out_valid), 128'(prev_re));
         if (lane_sel == 4'hF) begin
            n_sel++;
            last_sel_cyc = cyc;
         end
         if (lane_sel != '0 && !prev_sel) begin
            sel_rise_cyc = cyc;
            re_pending   = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: got ARM entry expected none");
            end else begin
               logic [127:0] e;
               e = exp_q.pop_front();
               if (lane_data !== e) begin
                  errors++;
                  $display("FAIL lane_data: got %0h expected %0h", lane_data, e);
               end
            end
         end
         if (global_re) begin
            n_re++;
            if (re_pending) begin
               first_re_cyc = cyc;
               re_pending   = 1'b0;
            end
            last_re_cyc = cyc;
         end
         if (out_valid) n_ov++;
         if (group_done) begin
            n_done++;
            done_cyc = cyc;
            chk("ready_at_done", 128'(in_ready), 128'(1));
         end
         if (err_timeout && !prev_tmo) tmo_cyc = cyc;
         prev_re  = global_re;
         prev_sel = (lane_sel != '0);
         prev_tmo = err_timeout;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_sel  = n_sel;
      b_re   = n_re;
      b_ov   = n_ov;
      b_done = n_done;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, input bit first);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      chk("accept_ready", 128'(in_ready), 128'(1));
      if (first) grp_acc = cyc + 1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic send_group(input vec_t v);
      exp_q.push_back(v.exp_data);
      for (int i = 0; i < v.n; i++)
         send_word(v.words[i*32 +: 32], v.last && (i == v.n - 1), i == 0);
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while (n_done == b_done && t < budget) begin
         step();
         t++;
      end
      chk("done_seen", 128'(n_done != b_done), 128'(1));
   endtask

   task automatic check_group(input string tag, input int lat, input int stalls);
      chk({tag, "_sel"},  128'(n_sel - b_sel), 128'(7));
      chk({tag, "_re"},   128'(n_re - b_re), 128'(7));
      chk({tag, "_ov"},   128'(n_ov - b_ov), 128'(7));
      chk({tag, "_done"}, 128'(n_done - b_done), 128'(1));
      chk({tag, "_gap"},  128'(first_re_cyc - last_sel_cyc - 1), 128'(3));
      chk({tag, "_span"}, 128'(last_re_cyc - first_re_cyc + 1), 128'(7 + stalls));
      if (lat >= 0) chk({tag, "_lat"}, 128'(done_cyc - grp_acc), 128'(lat));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      vecs[0] = '{4, 128'h100F0E0D_0C0B0A09_08070605_04030201, 1'b0,
                  128'h100F0E0D_0C0B0A09_08070605_04030201, 22};
      vecs[1] = '{2, 128'hFFFFFFFF_FFFFFFFF_A5A5A5A5_11223344, 1'b1,
                  128'h00000000_00000000_A5A5A5A5_11223344, 20};
      vecs[2] = '{1, 128'hDEADBEEF_DEADBEEF_DEADBEEF_80000001, 1'b1,
                  128'h00000000_00000000_00000000_80000001, 19};
      vecs[3] = '{3, 128'h44444444_33333333_22222222_11111111, 1'b1,
                  128'h00000000_33333333_22222222_11111111, 21};
      vecs[4] = '{4, 128'hFFFFFFFF_00000000_FFFFFFFF_12345678, 1'b1,
                  128'hFFFFFFFF_00000000_FFFFFFFF_12345678, 22};

      // Reset state and first edge after release
      step();
      step();
      chk("rst_ctrl", 128'({in_ready, lane_sel, global_re, out_valid, group_done, err_overflow, err_timeout}), '0);
      chk("rst_data", lane_data, '0);
      resetn = 1'b1;
      chk("ready_before_edge", 128'(in_ready), 128'(0));
      step();
      chk("ready_after_edge", 128'(in_ready), 128'(1));

      // Idle with no traffic
      snap();
      repeat (8) step();
      chk("idle_ready", 128'(in_ready), 128'(1));
      chk("idle_sel", 128'(n_sel - b_sel), 128'(0));
      chk("idle_re", 128'(n_re - b_re), 128'(0));

      // Table-driven groups with no stalls
      for (int i = 0; i < 5; i++) begin
         snap();
         send_group(vecs[i]);
         wait_done(60);
         check_group($sformatf("vec%0d", i), vecs[i].exp_lat, 0);
         chk($sformatf("vec%0d_errs", i), 128'({err_overflow, err_timeout}), '0);
         step();
      end

      // Three-cycle stall on lane 1 mid-DRAIN
      snap();
      send_group(vecs[0]);
      t = 0;
      while (n_re - b_re < 2 && t < 60) begin step(); t++; end
      force_e = 4'b0010;
      repeat (3) step();
      force_e = '0;
      wait_done(60);
      check_group("stall", 25, 3);
      chk("stall_tmo", 128'(err_timeout), 128'(0));
      step();

      // Locked group held in LOAD while lane 0 is not empty
      snap();
      force_ne = 4'b0001;
      send_group(vecs[1]);
      repeat (5) begin
         chk("hold_ready", 128'(in_ready), 128'(0));
         chk("hold_sel", 128'(lane_sel), '0);
         step();
      end
      force_ne = '0;
      t = cyc + 1;
      wait_done(60);
      chk("hold_arm_next", 128'(sel_rise_cyc - t), 128'(1));
      check_group("hold", -1, 0);
      step();

      // Lane 2 empty throughout DRAIN: watchdog abort
      snap();
      send_group(vecs[0]);
      t = 0;
      while (n_sel - b_sel < 7 && t < 60) begin step(); t++; end
      force_e = 4'b0100;
      t = 0;
      while (!err_timeout && t < 40) begin step(); t++; end
      chk("tmo_seen", 128'(err_timeout), 128'(1));
      chk("tmo_ready", 128'(in_ready), 128'(1));
      step();
      chk("tmo_delay", 128'(tmo_cyc - last_sel_cyc), 128'(19));
      chk("tmo_reads", 128'(n_re - b_re), 128'(0));
      chk("tmo_no_done", 128'(n_done - b_done), 128'(0));
      repeat (3) step();
      chk("tmo_sticky", 128'(err_timeout), 128'(1));
      force_e = '0;
      resetn = 1'b0;
      step();
      chk("tmo_cleared", 128'(err_timeout), 128'(0));
      resetn = 1'b1;
      step();

      // Overflow during ARM, sticky across group completion
      snap();
      send_group(vecs[2]);
      t = 0;
      while (lane_sel == '0 && t < 20) begin step(); t++; end
      chk("ovf_before", 128'(err_overflow), 128'(0));
      lane_full = 4'b1000;
      step();
      lane_full = '0;
      wait_done(60);
      check_group("ovf", 19, 0);
      repeat (4) step();
      chk("ovf_sticky", 128'(err_overflow), 128'(1));

      // Asynchronous reset mid-DRAIN
      snap();
      send_group(vecs[0]);
      t = 0;
      while (n_re - b_re < 3 && t < 60) begin step(); t++; end
      chk("pre_rst_re", 128'(global_re), 128'(1));
      #1 resetn = 1'b0;
      #1;
      chk("async_ctrl", 128'({in_ready, lane_sel, global_re, out_valid, group_done, err_overflow, err_timeout}), '0);
      chk("async_data", lane_data, '0);
      step();
      resetn = 1'b1;
      chk("rel_ready_low", 128'(in_ready), 128'(0));
      step();
      chk("rel_ready_high", 128'(in_ready), 128'(1));
      snap();
      repeat (10) step();
      chk("no_partial_re", 128'(n_re - b_re), 128'(0));
      chk("no_partial_ov", 128'(n_ov - b_ov), 128'(0));
      snap();
      send_group(vecs[0]);
      wait_done(60);
      check_group("post_rst", 22, 0);
      step();
      chk("sb_drained", 128'(exp_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
